// File: rtl/img_pkg.sv
// img_pkg: image geometry defaults, edge pixel codes and the 3x3 window type shared by the video pipeline.
package img_pkg;
  localparam int IMG_WIDTH_DEF = 640;
  localparam int IMG_HEIGHT_DEF = 480;
  localparam logic [11:0] EDGE_ON = 12'hFFF;
  localparam logic [11:0] EDGE_OFF = 12'h000;
  typedef logic [2:0][2:0] window3_t;
endpackage

// File: rtl/bit_line_buffer.sv
// bit_line_buffer: 1-bit line memory; dout is the value stored at addr before any write on this edge.
module bit_line_buffer #(
  parameter int DEPTH = 640,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic          din,
  output logic          dout
);
  logic [DEPTH-1:0] mem_q;
  always_ff @(posedge clk or posedge reset)
    if (reset) mem_q <= '0;
    else if (we) mem_q[addr] <= din;
  assign dout = mem_q[addr];
endmodule

// File: rtl/edge_dilate_filter.sv
// edge_dilate_filter: 3x3 binary dilate (ERODE=0) or erode (ERODE=1) of the thresholded edge stream.
// Define EDGE_COUNT_EN to add the per-frame edge-pixel counter on edge_count/count_valid.
module edge_dilate_filter import img_pkg::*; #(
  parameter int IMG_WIDTH = IMG_WIDTH_DEF,
  parameter int IMG_HEIGHT = IMG_HEIGHT_DEF,
  parameter bit ERODE = 1'b0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        de,
  input  logic [9:0]  x_coor,
  input  logic [8:0]  y_coor,
  input  logic [11:0] b_data,
  output logic        dven,
  output logic [11:0] d_data,
  output logic [18:0] edge_count,
  output logic        count_valid
);
  localparam int AW = $clog2(IMG_WIDTH);
  if (IMG_WIDTH < 3 || IMG_HEIGHT < 3) begin : g_bad_size
    $error("edge_dilate_filter: image must be at least 3x3");
  end
  logic pix, b1, b2, res, v1_q, dven_q;
  logic [11:0] d_data_q;
  window3_t win_q, win_d;
  assign pix = |b_data;
  bit_line_buffer #(.DEPTH(IMG_WIDTH)) u_buf1 (
    .clk(clk), .reset(reset), .we(de), .addr(x_coor[AW-1:0]), .din(pix), .dout(b1)
  );
  bit_line_buffer #(.DEPTH(IMG_WIDTH)) u_buf2 (
    .clk(clk), .reset(reset), .we(de), .addr(x_coor[AW-1:0]), .din(b1), .dout(b2)
  );
  // Row 2 is the oldest line (y-2), row 0 the current line; column 0 is the newest sample.
  assign win_d = de ? {win_q[2][1:0], b2, win_q[1][1:0], b1, win_q[0][1:0], pix} : win_q;
  assign res = ERODE ? &win_q : |win_q;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      win_q <= '0;
      v1_q <= 1'b0;
      dven_q <= 1'b0;
      d_data_q <= EDGE_OFF;
    end else begin
      win_q <= win_d;
      v1_q <= de && x_coor >= 10'd2 && y_coor >= 9'd2;
      dven_q <= v1_q;
      if (v1_q) d_data_q <= res ? EDGE_ON : EDGE_OFF;
    end
  assign dven = dven_q;
  assign d_data = d_data_q;
`ifdef EDGE_COUNT_EN
  logic start, last_q, fire_q, started_q, cv_q;
  logic [18:0] cnt_q, cnt_d, total_q, ec_q;
  assign start = de && x_coor == 10'd0 && y_coor == 9'd0;
  assign cnt_d = start ? '0 : cnt_q + 19'(v1_q & res);
  // The final total is snapshotted separately so a new frame starting right after the last sample cannot erase it.
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      cnt_q <= '0;
      total_q <= '0;
      ec_q <= '0;
      last_q <= 1'b0;
      fire_q <= 1'b0;
      started_q <= 1'b0;
      cv_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      last_q <= de && x_coor == 10'(IMG_WIDTH - 1) && y_coor == 9'(IMG_HEIGHT - 1);
      fire_q <= last_q && started_q;
      started_q <= start || (started_q && !last_q);
      if (last_q) total_q <= cnt_q + 19'(res);
      cv_q <= fire_q;
      if (fire_q) ec_q <= total_q;
    end
  assign edge_count = ec_q;
  assign count_valid = cv_q;
`else
  assign edge_count = '0;
  assign count_valid = 1'b0;
`endif
endmodule
